// File: rtl/digit_scan_pkg.sv
// Shared types and constants for the digit scan capture block.
// Holds the frame FSM state enum, gate pattern codes and the BCD digit limit.
package digit_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GOT_H = 2'd1,
      GOT_T = 2'd2
   } scan_state_t;

   localparam logic [2:0] PAT_HUNDS = 3'b011;
   localparam logic [2:0] PAT_TENS  = 3'b101;
   localparam logic [2:0] PAT_ONES  = 3'b110;
   localparam logic [2:0] PAT_BLANK = 3'b111;
   localparam logic [3:0] BCD_MAX   = 4'd9;

   // True only for the three single-gate-low patterns that select a digit.
   function automatic logic pat_is_digit(input logic [2:0] pat);
      return (pat == PAT_HUNDS) || (pat == PAT_TENS) || (pat == PAT_ONES);
   endfunction

endpackage

// File: rtl/digit_scan_capture_stability_filter.sv
// Input register, saturating run counter and one-shot accept strobe for the scan bus.
// A {pattern,bcd} sample is accepted once, when its run length reaches STABLE_CYCLES.
module scan_stability_filter
   import digit_scan_pkg::*;
#(
   parameter int STABLE_CYCLES = 1,
   parameter int CNT_W         = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] pat,
   input  logic [3:0] bcd,
   output logic       vld_p0,
   output logic [2:0] pat_p0,
   output logic [3:0] bcd_p0
);

   localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_SAT    = '1;

   logic [CNT_W-1:0] run_cnt;

   // Stage p0: bus sample register (data, never reset)
   always_ff @(posedge clk) begin
      pat_p0 <= pat;
      bcd_p0 <= bcd;
   end

   // Reset parks the counter at saturation so a value held across reset is not re-accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_cnt <= CNT_SAT;
      end else if ({pat, bcd} != {pat_p0, bcd_p0}) begin
         run_cnt <= CNT_W'(1);
      end else if (run_cnt != CNT_SAT) begin
         run_cnt <= run_cnt + CNT_W'(1);
      end
   end

   assign vld_p0 = (run_cnt == STABLE_LIM) && (pat_p0 != PAT_BLANK);

endmodule

// File: rtl/digit_scan_capture.sv
// Receive-side monitor for the 3-digit multiplexed display scan bus: deglitch, order check, commit.
// Optional macro SCAN_ERR_COUNT_EN adds a saturating err_count output.
module digit_scan_capture
   import digit_scan_pkg::*;
#(
   parameter int STABLE_CYCLES  = 1,
   parameter int CNT_W          = 24,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       gateOne,
   input  logic       gateTwo,
   input  logic       gateThree,
   input  logic [3:0] in_bcd,
   output logic [3:0] hunds_o,
   output logic [3:0] tens_o,
   output logic [3:0] ones_o,
   output logic       frame_valid,
   output logic       frame_err,
   output logic       link_alive
`ifdef SCAN_ERR_COUNT_EN
   ,
   output logic [7:0] err_count
`endif
);

   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

   logic [2:0]  pat;
   logic        vld_p0;
   logic [2:0]  pat_p0;
   logic [3:0]  bcd_p0;

   scan_state_t state, state_nxt;
   logic        load_h, load_t, commit, err_nxt, clr_to;
   logic [3:0]  shadow_h, shadow_t;
   logic [CNT_W-1:0] to_cnt;
   logic        seen;

   assign pat = {gateThree, gateTwo, gateOne};

   scan_stability_filter #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
   ) u_filter (
      .clk    (clk),
      .rst    (rst),
      .pat    (pat),
      .bcd    (in_bcd),
      .vld_p0 (vld_p0),
      .pat_p0 (pat_p0),
      .bcd_p0 (bcd_p0)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_h    = 1'b0;
      load_t    = 1'b0;
      commit    = 1'b0;
      err_nxt   = 1'b0;
      clr_to    = 1'b0;
      if (vld_p0) begin
         if (!pat_is_digit(pat_p0)) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
         end else begin
            // Any well-formed gate pattern proves the link is alive, even with a bad digit.
            clr_to = 1'b1;
            if (bcd_p0 > BCD_MAX) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               case (pat_p0)
                  PAT_HUNDS: begin
                     load_h    = 1'b1;
                     state_nxt = GOT_H;
                  end
                  PAT_TENS: begin
                     if (state == GOT_H) begin
                        load_t    = 1'b1;
                        state_nxt = GOT_T;
                     end else begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                     end
                  end
                  PAT_ONES: begin
                     if (state == GOT_T) commit = 1'b1;
                     else                err_nxt = 1'b1;
                     state_nxt = IDLE;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // Stage p1: shadow digits (data) and committed outputs
   always_ff @(posedge clk) begin
      if (load_h) shadow_h <= bcd_p0;
      if (load_t) shadow_t <= bcd_p0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hunds_o     <= 4'd0;
         tens_o      <= 4'd0;
         ones_o      <= 4'd0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         if (commit) begin
            hunds_o <= shadow_h;
            tens_o  <= shadow_t;
            ones_o  <= bcd_p0;
         end
         frame_valid <= commit;
         frame_err   <= err_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt <= '0;
         seen   <= 1'b0;
      end else begin
         if (clr_to)                to_cnt <= '0;
         else if (to_cnt < TO_LIM)  to_cnt <= to_cnt + CNT_W'(1);
         if (clr_to) seen <= 1'b1;
      end
   end

   assign link_alive = seen && (to_cnt < TO_LIM);

`ifdef SCAN_ERR_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst)                                err_count <= 8'd0;
      else if (frame_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_digit_scan_capture.sv
// Self-checking bench for digit_scan_capture: directed vector table, multi-cycle corner
// sequences and randomized scans checked against a frame-level reference model.
module tb_digit_scan_capture;

   localparam int TMO = 64;
   localparam logic [2:0] H  = 3'b011;
   localparam logic [2:0] T  = 3'b101;
   localparam logic [2:0] O  = 3'b110;
   localparam logic [2:0] BL = 3'b111;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       g1 = 1'b1, g2 = 1'b1, g3 = 1'b1;
   logic [3:0] bcd = 4'd0;

   logic [3:0] h1, t1, o1, h3, t3, o3;
   logic       v1, e1, a1, v3, e3, a3;
`ifdef SCAN_ERR_COUNT_EN
   logic [7:0] ec1, ec3;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   digit_scan_capture #(.STABLE_CYCLES(1), .CNT_W(24), .TIMEOUT_CYCLES(TMO)) dut1 (
      .clk(clk), .rst(rst), .gateOne(g1), .gateTwo(g2), .gateThree(g3), .in_bcd(bcd),
      .hunds_o(h1), .tens_o(t1), .ones_o(o1),
      .frame_valid(v1), .frame_err(e1), .link_alive(a1)
`ifdef SCAN_ERR_COUNT_EN
      , .err_count(ec1)
`endif
   );

   digit_scan_capture #(.STABLE_CYCLES(3), .CNT_W(24), .TIMEOUT_CYCLES(TMO)) dut3 (
      .clk(clk), .rst(rst), .gateOne(g1), .gateTwo(g2), .gateThree(g3), .in_bcd(bcd),
      .hunds_o(h3), .tens_o(t3), .ones_o(o3),
      .frame_valid(v3), .frame_err(e3), .link_alive(a3)
`ifdef SCAN_ERR_COUNT_EN
      , .err_count(ec3)
`endif
   );

   // Reference model (STABLE_CYCLES=1): a sample is accepted when it differs from the one before.
   logic [6:0] m_last;
   logic [6:0] prev;
   bit         prev_has;
   logic [3:0] m_h, m_t, m_o;
   bit         m_valid, m_err, m_seen;
   int         m_to, m_ec;
   logic [3:0] q[$];

   task automatic model_reset(input logic [2:0] p, input logic [3:0] b);
      m_h = 0; m_t = 0; m_o = 0;
      m_valid = 0; m_err = 0; m_seen = 0;
      m_to = 0; m_ec = 0;
      q.delete();
      m_last = {p, b};
      prev_has = 0;
   endtask

   task automatic model_edge(input bit has, input logic [6:0] x);
      logic [2:0] p;
      logic [3:0] b;
      bit clr;
      p = x[6:4];
      b = x[3:0];
      clr = 0;
      m_valid = 0;
      m_err = 0;
      if (has) begin
         if (x != m_last && p != BL) begin
            if (p != H && p != T && p != O) begin
               m_err = 1;
               q.delete();
            end else begin
               clr = 1;
               m_seen = 1;
               if (b > 9) begin
                  m_err = 1;
                  q.delete();
               end else if (p == H) begin
                  q.delete();
                  q.push_back(b);
               end else if (p == T) begin
                  if (q.size() == 1) q.push_back(b);
                  else begin m_err = 1; q.delete(); end
               end else begin
                  if (q.size() == 2) begin
                     m_h = q[0]; m_t = q[1]; m_o = b; m_valid = 1;
                  end else m_err = 1;
                  q.delete();
               end
            end
         end
         m_last = x;
      end
      if (clr) m_to = 0;
      else if (m_to < TMO) m_to++;
      if (m_err && m_ec < 255) m_ec++;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic [2:0] p, input logic [3:0] b, input logic r);
      @(negedge clk);
      {g3, g2, g1} = p;
      bcd = b;
      rst = r;
      @(posedge clk);
      #1;
      if (r) model_reset(p, b);
      else begin
         model_edge(prev_has, prev);
         prev_has = 1;
         prev = {p, b};
      end
      chk("m_hunds", int'(h1), int'(m_h));
      chk("m_tens", int'(t1), int'(m_t));
      chk("m_ones", int'(o1), int'(m_o));
      chk("m_valid", int'(v1), int'(m_valid));
      chk("m_err", int'(e1), int'(m_err));
      chk("m_alive", int'(a1), int'(m_seen && (m_to < TMO)));
`ifdef SCAN_ERR_COUNT_EN
      chk("m_errcnt", int'(ec1), m_ec);
`endif
   endtask

   typedef struct {
      logic [2:0] p;
      logic [3:0] b;
      logic [3:0] h, t, o;
      logic       v, e, a;
   } vec_t;

   vec_t vec[17];

   initial begin
      int vcnt, ecnt;
      vec[0]  = '{H, 4'd7,  0, 0, 0, 0, 0, 0};
      vec[1]  = '{T, 4'd4,  0, 0, 0, 0, 0, 1};
      vec[2]  = '{O, 4'd2,  0, 0, 0, 0, 0, 1};
      vec[3]  = '{BL, 4'd0, 7, 4, 2, 1, 0, 1};
      vec[4]  = '{H, 4'd1,  7, 4, 2, 0, 0, 1};
      vec[5]  = '{O, 4'd5,  7, 4, 2, 0, 0, 1};
      vec[6]  = '{BL, 4'd0, 7, 4, 2, 0, 1, 1};
      vec[7]  = '{3'b001, 4'd3, 7, 4, 2, 0, 0, 1};
      vec[8]  = '{BL, 4'd0, 7, 4, 2, 0, 1, 1};
      vec[9]  = '{H, 4'd9,  7, 4, 2, 0, 0, 1};
      vec[10] = '{T, 4'd12, 7, 4, 2, 0, 0, 1};
      vec[11] = '{BL, 4'd0, 7, 4, 2, 0, 1, 1};
      vec[12] = '{H, 4'd3,  7, 4, 2, 0, 0, 1};
      vec[13] = '{T, 4'd0,  7, 4, 2, 0, 0, 1};
      vec[14] = '{O, 4'd9,  7, 4, 2, 0, 0, 1};
      vec[15] = '{BL, 4'd0, 3, 0, 9, 1, 0, 1};
      vec[16] = '{BL, 4'd0, 3, 0, 9, 0, 0, 1};

      prev_has = 0;
      prev = '0;
      model_reset(BL, 4'd0);

      // Reset state
      step(BL, 4'd0, 1);
      step(BL, 4'd0, 1);
      chk("rst_hunds", int'(h1), 0);
      chk("rst_ones", int'(o1), 0);
      chk("rst_valid", int'(v1), 0);
      chk("rst_err", int'(e1), 0);
      chk("rst_alive", int'(a1), 0);

      // Directed frames, skipped digit, illegal pattern, BCD>9, recovery
      for (int i = 0; i < 17; i++) begin
         step(vec[i].p, vec[i].b, 0);
         chk($sformatf("tbl%0d_hunds", i), int'(h1), int'(vec[i].h));
         chk($sformatf("tbl%0d_tens", i), int'(t1), int'(vec[i].t));
         chk($sformatf("tbl%0d_ones", i), int'(o1), int'(vec[i].o));
         chk($sformatf("tbl%0d_valid", i), int'(v1), int'(vec[i].v));
         chk($sformatf("tbl%0d_err", i), int'(e1), int'(vec[i].e));
         chk($sformatf("tbl%0d_alive", i), int'(a1), int'(vec[i].a));
      end

      // Timeout: blank bus after a frame, then recovery on the next digit
      for (int i = 0; i < TMO + 8; i++) begin
         step(BL, 4'd0, 0);
         if (i == TMO - 16) chk("to_still_alive", int'(a1), 1);
      end
      chk("to_dropped", int'(a1), 0);
      step(H, 4'd2, 0);
      step(BL, 4'd0, 0);
      chk("to_recovered", int'(a1), 1);

      // Reset while in GOT_T with the ones digit held through and after reset
      step(H, 4'd1, 0);
      step(T, 4'd2, 0);
      step(BL, 4'd0, 0);
      step(O, 4'd3, 1);
      vcnt = 0; ecnt = 0;
      for (int i = 0; i < 4; i++) begin
         step(O, 4'd3, 0);
         vcnt += int'(v1);
         ecnt += int'(e1);
      end
      chk("rstmid_hunds", int'(h1), 0);
      chk("rstmid_tens", int'(t1), 0);
      chk("rstmid_ones", int'(o1), 0);
      chk("rstmid_valid_pulses", vcnt, 0);
      chk("rstmid_err_pulses", ecnt, 0);
`ifdef SCAN_ERR_COUNT_EN
      chk("rstmid_errcnt", int'(ec1), 0);
      for (int k = 0; k < 3; k++) begin
         step(BL, 4'd0, 0);
         step(3'b001, 4'd0, 0);
         step(BL, 4'd0, 0);
         step(T, 4'd12, 0);
         step(BL, 4'd0, 0);
      end
      step(BL, 4'd0, 0);
      chk("errcnt_after3x", int'(ec1), 6);
`endif

      // STABLE_CYCLES=3 deglitch: one-cycle TENS glitch between HUNDS runs
      step(BL, 4'd0, 1);
      step(BL, 4'd0, 1);
      chk("s4_rst_hunds", int'(h3), 0);
      chk("s4_rst_valid", int'(v3), 0);
      vcnt = 0; ecnt = 0;
      for (int i = 0; i < 3; i++) begin step(H, 4'd5, 0); vcnt += int'(v3); ecnt += int'(e3); end
      step(T, 4'd3, 0); vcnt += int'(v3); ecnt += int'(e3);
      for (int i = 0; i < 3; i++) begin step(H, 4'd5, 0); vcnt += int'(v3); ecnt += int'(e3); end
      for (int i = 0; i < 3; i++) begin step(T, 4'd3, 0); vcnt += int'(v3); ecnt += int'(e3); end
      for (int i = 0; i < 3; i++) begin step(O, 4'd8, 0); vcnt += int'(v3); ecnt += int'(e3); end
      for (int i = 0; i < 3; i++) begin step(BL, 4'd0, 0); vcnt += int'(v3); ecnt += int'(e3); end
      chk("s4_valid_pulses", vcnt, 1);
      chk("s4_err_pulses", ecnt, 0);
      chk("s4_hunds", int'(h3), 5);
      chk("s4_tens", int'(t3), 3);
      chk("s4_ones", int'(o3), 8);

      // Randomized scans against the model
      step(BL, 4'd0, 1);
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 9) < 4) begin
            logic [2:0] fp[3];
            fp[0] = H; fp[1] = T; fp[2] = O;
            for (int d = 0; d < 3; d++) begin
               logic [3:0] rb;
               rb = 4'($urandom_range(0, 10));
               for (int k = 0; k < int'($urandom_range(1, 2)); k++) step(fp[d], rb, 0);
            end
         end else begin
            int sel;
            logic [2:0] rp;
            sel = int'($urandom_range(0, 9));
            if (sel < 2)      rp = H;
            else if (sel < 4) rp = T;
            else if (sel < 6) rp = O;
            else if (sel < 8) rp = BL;
            else              rp = 3'($urandom_range(0, 7));
            step(rp, 4'($urandom_range(0, 15)), 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
